// File: rtl/adder_arbiter_pkg.sv
// Shared defaults for the adder arbiter slice.
package adder_arbiter_pkg;
    localparam int DEF_WORD_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;

    typedef enum logic {
        RESP_EMPTY = 1'b0,
        RESP_FULL  = 1'b1
    } resp_state_t;
endpackage

// File: rtl/adder_arbiter_if.sv
// Requester and response handshake bundle of the shared adder.
interface adder_arbiter_if
    import adder_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_a;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_b;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [ID_WIDTH-1:0]           resp_id;
    logic [WORD_WIDTH-1:0]         resp_y;
    logic                          resp_cout;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_y, resp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_y, resp_cout
    );
endinterface

// File: rtl/Adder.sv
// Plain ripple-style adder with carry-out.
module Adder #(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic [WORD_WIDTH-1:0] y,
    output logic                  cout
);
    assign {cout, y} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/rr_grant.sv
// Rotating priority encoder: first valid index at or after ptr.
module rr_grant #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic                found,
    output logic [ID_WIDTH-1:0] g
);
    int idx;

    // With no valid requester g falls back to rr_ptr.
    always_comb begin
        found = 1'b0;
        g     = rr_ptr;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                g     = ID_WIDTH'(idx);
            end
        end
    end
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one adder among NUM_REQ requesters,
// with a single-entry registered result stage.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input logic             clk,
    input logic             reset,
    adder_arbiter_if.slave  bus
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    resp_state_t           state;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   g;
    logic                  found;
    logic                  accept;
    logic                  fire;
    logic [NUM_REQ-1:0]    ready;
    logic [WORD_WIDTH-1:0] op_a;
    logic [WORD_WIDTH-1:0] op_b;
    logic [WORD_WIDTH-1:0] sum;
    logic                  carry;
    logic [ID_WIDTH-1:0]   id_q;
    logic [WORD_WIDTH-1:0] y_q;
    logic                  cout_q;

    rr_grant #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_grant (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .found     (found),
        .g         (g)
    );

    assign op_a = bus.req_a[int'(g)*WORD_WIDTH +: WORD_WIDTH];
    assign op_b = bus.req_b[int'(g)*WORD_WIDTH +: WORD_WIDTH];

    Adder #(.WORD_WIDTH(WORD_WIDTH)) u_adder (
        .a    (op_a),
        .b    (op_b),
        .y    (sum),
        .cout (carry)
    );

    assign accept = (state == RESP_EMPTY) || bus.resp_ready;
    // Reset masks the grant so nothing handshakes while it is held.
    assign fire   = found && accept && !reset;

    always_comb begin
        ready = '0;
        if (fire) ready[g] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RESP_EMPTY;
            rr_ptr <= '0;
            id_q   <= '0;
            y_q    <= '0;
            cout_q <= 1'b0;
        end else if (fire) begin
            state  <= RESP_FULL;
            id_q   <= g;
            y_q    <= sum;
            cout_q <= carry;
            if (g == ID_WIDTH'(NUM_REQ - 1)) rr_ptr <= '0;
            else rr_ptr <= g + 1'b1;
        end else if (bus.resp_ready) begin
            state <= RESP_EMPTY;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = (state == RESP_FULL);
    assign bus.resp_id    = id_q;
    assign bus.resp_y     = y_q;
    assign bus.resp_cout  = cout_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed vector bench for the shared-adder arbiter.
module tb_adder_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    adder_arbiter_if #(.WORD_WIDTH(8), .NUM_REQ(4)) bus ();

    adder_arbiter #(.WORD_WIDTH(8), .NUM_REQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic [3:0]  exp_ready;
        logic        exp_rv;
        logic [1:0]  exp_id;
        logic [7:0]  exp_y;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] a,
                         input logic [31:0] b, input logic rr);
        bus.req_valid  = v;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.resp_ready = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic rv,
                            input logic [1:0] id, input logic [7:0] y,
                            input logic c);
        chk({tag, ".valid"}, 32'(bus.resp_valid), 32'(rv));
        chk({tag, ".id"}, 32'(bus.resp_id), 32'(id));
        chk({tag, ".y"}, 32'(bus.resp_y), 32'(y));
        chk({tag, ".cout"}, 32'(bus.resp_cout), 32'(c));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // {valid, a, b, rr, ready, rv, id, y, cout}
        vecs[0]  = '{4'b0010, 32'h0000_0100, 32'h0000_0300, 1,
                     4'b0010, 1, 2'd1, 8'd4, 0};
        vecs[1]  = '{4'b0000, 32'h0, 32'h0, 1,
                     4'b0000, 0, 2'd1, 8'd4, 0};
        vecs[2]  = '{4'b0001, 32'h0000_00C8, 32'h0000_0064, 1,
                     4'b0001, 1, 2'd0, 8'd44, 1};
        vecs[3]  = '{4'b0001, 32'h0000_00FF, 32'h0000_0001, 1,
                     4'b0001, 1, 2'd0, 8'd0, 1};
        vecs[4]  = '{4'b0000, 32'h0, 32'h0, 1,
                     4'b0000, 0, 2'd0, 8'd0, 1};
        vecs[5]  = '{4'b0100, 32'h0017_0000, 32'h0025_0000, 0,
                     4'b0100, 1, 2'd2, 8'd60, 0};
        vecs[6]  = '{4'b1000, 32'h0500_0000, 32'h0600_0000, 0,
                     4'b0000, 1, 2'd2, 8'd60, 0};
        vecs[7]  = vecs[6];
        vecs[8]  = vecs[6];
        vecs[9]  = '{4'b1000, 32'h0500_0000, 32'h0600_0000, 1,
                     4'b1000, 1, 2'd3, 8'd11, 0};
        vecs[10] = '{4'b0000, 32'h0, 32'h0, 1,
                     4'b0000, 0, 2'd3, 8'd11, 0};

        reset = 1'b1;
        drive(4'b0000, 32'h0, 32'h0, 1'b1);
        #3;
        chk_resp("reset", 0, 2'd0, 8'd0, 0);
        chk("reset.ready", 32'(bus.req_ready), 32'h0);
        #9;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rr);
            #1;
            chk($sformatf("v%0d.ready", i), 32'(bus.req_ready),
                32'(vecs[i].exp_ready));
            tick();
            chk_resp($sformatf("v%0d", i), vecs[i].exp_rv,
                     vecs[i].exp_id, vecs[i].exp_y, vecs[i].exp_cout);
        end

        // Round-robin with all requesters valid, starting from reset
        reset = 1'b1;
        #1;
        reset = 1'b0;
        drive(4'b1111, 32'h0403_0201, 32'h8080_8080, 1'b1);
        for (int k = 0; k < 7; k++) begin
            int gexp;
            gexp = k % 4;
            #1;
            chk($sformatf("rr%0d.ready", k), 32'(bus.req_ready),
                32'(1 << gexp));
            tick();
            chk_resp($sformatf("rr%0d", k), 1, 2'(gexp),
                     8'(gexp + 1 + 128), 0);
        end

        // Only 0 and 3 valid with the pointer at 3
        drive(4'b1001, 32'h0403_0201, 32'h8080_8080, 1'b1);
        #1;
        chk("w0.ready", 32'(bus.req_ready), 32'h8);
        tick();
        chk_resp("w0", 1, 2'd3, 8'd132, 0);
        #1;
        chk("w1.ready", 32'(bus.req_ready), 32'h1);
        tick();
        chk_resp("w1", 1, 2'd0, 8'd129, 0);

        // Asynchronous reset while a result is held
        drive(4'b1001, 32'h0403_0201, 32'h8080_8080, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_resp("mid_rst", 0, 2'd0, 8'd0, 0);
        chk("mid_rst.ready", 32'(bus.req_ready), 32'h0);
        tick();
        chk("mid_rst.hold", 32'(bus.resp_valid), 32'h0);
        #2;
        reset = 1'b0;
        drive(4'b1100, 32'h0403_0201, 32'h8080_8080, 1'b1);
        #1;
        chk("post_rst.ready", 32'(bus.req_ready), 32'h4);
        tick();
        chk_resp("post_rst", 1, 2'd2, 8'd131, 0);

        // Idle cycles leave the pointer at 3
        drive(4'b0000, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("idle%0d.ready", k), 32'(bus.req_ready), 32'h0);
            tick();
            chk($sformatf("idle%0d.valid", k),
                32'(bus.resp_valid), 32'h0);
        end
        drive(4'b1111, 32'h0403_0201, 32'h8080_8080, 1'b1);
        #1;
        chk("idle_ptr.ready", 32'(bus.req_ready), 32'h8);
        tick();
        chk_resp("idle_ptr", 1, 2'd3, 8'd132, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
